// File: rtl/fetch_server.sv
// Instruction-fetch stage: pc, instruction memory, stall/redirect, HALT and fault handling.
// Optional FETCH_PERF_EN adds saturating fetch/bubble/redirect counters.
module fetch_server #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter bit              BYTE_ADDR  = 1'b0,
  parameter string           INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hlt,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  output logic [XLEN-1:0]               instruction,
  output logic [XLEN-1:0]               pc,
  output logic [XLEN-1:0]               next_pc,
  output logic                          inst_valid,
  output logic                          bubble,
  output logic                          halted,
  output logic                          fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                   perf_fetched,
  output logic [31:0]                   perf_bubbles,
  output logic [31:0]                   perf_redirects
`endif
);

  localparam int unsigned     AW   = $clog2(IMEM_DEPTH);
  localparam logic [XLEN-1:0] STEP = BYTE_ADDR ? XLEN'(4) : XLEN'(1);
  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT, S_FAULT} state_t;

  state_t            r_state, w_state;
  logic [XLEN-1:0]   r_pc, w_pc;
  logic [XLEN-1:0]   r_next_pc, w_next_pc;
  logic              r_bubble, w_bubble;
  logic              r_boot, w_boot;
  logic [XLEN-1:0]   r_mem [IMEM_DEPTH];
  logic [AW-1:0]     w_rd_idx;
  logic [XLEN-1:0]   w_mem_word;
  logic [XLEN-1:0]   w_target;
  logic              w_move;
  logic              w_halt_op;

  function automatic logic [XLEN-1:0] word_idx(input logic [XLEN-1:0] a);
    return BYTE_ADDR ? (a >> 2) : a;
  endfunction

  function automatic logic addr_legal(input logic [XLEN-1:0] a);
    return (word_idx(a) < XLEN'(IMEM_DEPTH)) && !(BYTE_ADDR && (a[1:0] != 2'b00));
  endfunction

  assign w_rd_idx   = AW'(word_idx(r_pc));
  assign w_mem_word = r_mem[w_rd_idx];
  assign w_halt_op  = (w_mem_word[6:0] == 7'h7F);

  assign instruction = (r_state == S_FAULT) ? NOP : w_mem_word;
  assign pc          = r_pc;
  assign next_pc     = r_next_pc;
  assign bubble      = r_bubble;
  assign halted      = (r_state == S_HALT);
  assign fault       = (r_state == S_FAULT);
  assign inst_valid  = (r_state == S_RUN) && !r_bubble;

  // Program load: only while in reset or parked in HALT.
  always_ff @(posedge clk) begin
    if (imem_we && (rst || (r_state == S_HALT && !hlt)) && (32'(imem_waddr) < IMEM_DEPTH))
      r_mem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_PC;
      r_next_pc <= RESET_PC + STEP;
      r_bubble  <= 1'b1;
      r_boot    <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_pc      <= w_pc;
      r_next_pc <= w_next_pc;
      r_bubble  <= w_bubble;
      r_boot    <= w_boot;
    end
  end

  // r_boot marks the post-reset bubble: it is cleared without advancing pc,
  // whereas the stall-recovery bubble advances pc on the following edge.
  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_next_pc = r_next_pc;
    w_bubble  = r_bubble;
    w_boot    = r_boot;
    w_target  = '0;
    w_move    = 1'b0;
    if (!hlt) begin
      case (r_state)
        S_RUN: begin
          if (redirect_valid) begin
            w_target = redirect_pc;
            w_move   = 1'b1;
            w_boot   = 1'b0;
          end else if (stall) begin
            w_state  = S_STALL;
            w_bubble = 1'b1;
          end else if (r_boot) begin
            w_boot   = 1'b0;
            w_bubble = 1'b0;
          end else if (!r_bubble && w_halt_op) begin
            w_state = S_HALT;
          end else begin
            w_target = r_pc + STEP;
            w_move   = 1'b1;
          end
        end
        S_STALL: begin
          if (redirect_valid) begin
            w_target = redirect_pc;
            w_move   = 1'b1;
            w_boot   = 1'b0;
          end else if (!stall) begin
            w_state  = S_RUN;
            w_bubble = 1'b1;
          end
        end
        default: ;
      endcase
      if (w_move) begin
        w_pc      = w_target;
        w_next_pc = w_target + STEP;
        if (addr_legal(w_target)) begin
          w_state  = S_RUN;
          w_bubble = 1'b0;
        end else begin
          w_state  = S_FAULT;
          w_bubble = 1'b1;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic        w_active;
  logic [31:0] r_perf_fetched, r_perf_bubbles, r_perf_redirects;

  assign w_active       = (r_state == S_RUN) || (r_state == S_STALL);
  assign perf_fetched   = r_perf_fetched;
  assign perf_bubbles   = r_perf_bubbles;
  assign perf_redirects = r_perf_redirects;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched   <= '0;
      r_perf_bubbles   <= '0;
      r_perf_redirects <= '0;
    end else if (!hlt) begin
      if (inst_valid && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (r_bubble && w_active && (r_perf_bubbles != '1))
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (redirect_valid && w_active && (r_perf_redirects != '1))
        r_perf_redirects <= r_perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_server.sv
// Bench for fetch_server: word-indexed and byte-addressed instances driven in lockstep
// against a behavioural model, with directed scenarios followed by random traffic.
module tb_fetch_server;

  localparam int M_RUN = 0, M_STALL = 1, M_HALT = 2, M_FAULT = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, hlt, stall, redir_v, we;
  logic [31:0] redir_pc, wdata;
  logic [5:0]  waddr;

  logic [31:0] d_instr [2], d_pc [2], d_npc [2];
  logic        d_iv [2], d_bub [2], d_hlt [2], d_flt [2];
`ifdef FETCH_PERF_EN
  logic [31:0] d_pf [2], d_pb [2], d_pr [2];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  logic [31:0] m_pc [2];
  int          m_st [2];
  bit          m_bub [2], m_boot [2];
  logic [31:0] m_mem [2][64];
  int unsigned m_pf [2], m_pb [2], m_pr [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fetch_server #(
      .XLEN(32), .IMEM_DEPTH(64), .RESET_PC(32'h0), .BYTE_ADDR(g == 1)
    ) u_dut (
      .clk(clk), .rst(rst), .hlt(hlt), .stall(stall),
      .redirect_valid(redir_v), .redirect_pc(redir_pc),
      .imem_we(we), .imem_waddr(waddr), .imem_wdata(wdata),
      .instruction(d_instr[g]), .pc(d_pc[g]), .next_pc(d_npc[g]),
      .inst_valid(d_iv[g]), .bubble(d_bub[g]), .halted(d_hlt[g]), .fault(d_flt[g])
`ifdef FETCH_PERF_EN
      , .perf_fetched(d_pf[g]), .perf_bubbles(d_pb[g]), .perf_redirects(d_pr[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] step_of(int k);
    return (k == 0) ? 32'd1 : 32'd4;
  endfunction

  function automatic bit addr_ok(int k, logic [31:0] a);
    return (a % step_of(k) == 0) && (a / step_of(k) < 64);
  endfunction

  function automatic logic [31:0] m_instr(int k);
    int idx;
    if (m_st[k] == M_FAULT) return NOP;
    idx = int'(m_pc[k] / step_of(k));
    return m_mem[k][idx];
  endfunction

  task automatic m_goto(int k, logic [31:0] t);
    m_pc[k] = t;
    if (addr_ok(k, t)) begin m_st[k] = M_RUN; m_bub[k] = 0; end
    else begin m_st[k] = M_FAULT; m_bub[k] = 1; end
  endtask

  // One clock edge of the specified behaviour, applied to the inputs present at that edge.
  task automatic m_step(int k);
    logic [31:0] cur;
    bit          active;
    if (rst) begin
      if (we) m_mem[k][waddr] = wdata;
      m_pc[k] = 32'h0; m_st[k] = M_RUN; m_bub[k] = 1; m_boot[k] = 1;
      m_pf[k] = 0; m_pb[k] = 0; m_pr[k] = 0;
      return;
    end
    if (hlt) return;
    cur    = m_instr(k);
    active = (m_st[k] == M_RUN) || (m_st[k] == M_STALL);
    if (m_st[k] == M_RUN && !m_bub[k]) m_pf[k]++;
    if (active && m_bub[k]) m_pb[k]++;
    if (active && redir_v) m_pr[k]++;
    if (m_st[k] == M_HALT && we) m_mem[k][waddr] = wdata;
    if (m_st[k] == M_RUN) begin
      if (redir_v) begin m_boot[k] = 0; m_goto(k, redir_pc); end
      else if (stall) begin m_st[k] = M_STALL; m_bub[k] = 1; end
      else if (m_boot[k]) begin m_boot[k] = 0; m_bub[k] = 0; end
      else if (!m_bub[k] && cur[6:0] == 7'h7F) m_st[k] = M_HALT;
      else m_goto(k, m_pc[k] + step_of(k));
    end else if (m_st[k] == M_STALL) begin
      if (redir_v) begin m_boot[k] = 0; m_goto(k, redir_pc); end
      else if (!stall) begin m_st[k] = M_RUN; m_bub[k] = 1; end
    end
  endtask

  task automatic cmp_model(int k);
    chk($sformatf("m%0d_pc", k), d_pc[k], m_pc[k]);
    chk($sformatf("m%0d_next_pc", k), d_npc[k], m_pc[k] + step_of(k));
    chk($sformatf("m%0d_bubble", k), 32'(d_bub[k]), 32'(m_bub[k]));
    chk($sformatf("m%0d_valid", k), 32'(d_iv[k]), 32'(m_st[k] == M_RUN && !m_bub[k]));
    chk($sformatf("m%0d_halted", k), 32'(d_hlt[k]), 32'(m_st[k] == M_HALT));
    chk($sformatf("m%0d_fault", k), 32'(d_flt[k]), 32'(m_st[k] == M_FAULT));
    chk($sformatf("m%0d_instr", k), d_instr[k], m_instr(k));
`ifdef FETCH_PERF_EN
    chk($sformatf("m%0d_perf_fetched", k), d_pf[k], m_pf[k]);
    chk($sformatf("m%0d_perf_bubbles", k), d_pb[k], m_pb[k]);
    chk($sformatf("m%0d_perf_redirects", k), d_pr[k], m_pr[k]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) m_step(k);
    #1;
    for (int k = 0; k < 2; k++) cmp_model(k);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word(bit want_halt);
    logic [31:0] r;
    r = $urandom();
    return want_halt ? {r[31:7], 7'h7F} : {r[31:7], 7'h13};
  endfunction

  initial begin
    rst = 1'b1; hlt = 1'b0; stall = 1'b0; redir_v = 1'b0; redir_pc = '0;
    we = 1'b0; waddr = '0; wdata = '0;
    for (int k = 0; k < 2; k++) begin m_pc[k] = '0; m_st[k] = M_RUN; m_bub[k] = 1; m_boot[k] = 1; end

    // Load the whole memory while in reset: NOP,NOP,NOP,HALT then filler.
    for (int i = 0; i < 64; i++) begin
      we = 1'b1; waddr = 6'(i);
      wdata = (i < 3) ? NOP : (i == 3) ? 32'h0000_007F : rand_word(1'b0);
      tick();
    end
    we = 1'b0;
    chk("rst_pc", d_pc[0], 32'd0);
    chk("rst_next_pc", d_npc[0], 32'd1);
    chk("rst_bubble", 32'(d_bub[0]), 32'd1);
    chk("rst_byte_next_pc", d_npc[1], 32'd4);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tick();
      chk("run_pc", d_pc[0], 32'(i));
      chk("run_valid", 32'(d_iv[0]), 32'd1);
    end
    tick();
    chk("halt_flag", 32'(d_hlt[0]), 32'd1);
    chk("halt_pc", d_pc[0], 32'd3);
    chk("halt_valid", 32'(d_iv[0]), 32'd0);
    chk("halt_byte_pc", d_pc[1], 32'd12);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", d_pf[0], 32'd4);
    chk("perf_redirects", d_pr[0], 32'd0);
`endif
    redir_v = 1'b1; redir_pc = 32'd8; stall = 1'b1;
    tick();
    redir_v = 1'b0; stall = 1'b0;
    chk("halt_ignores_redirect", d_pc[0], 32'd3);

    // Program load in HALT, then reset and read it back.
    we = 1'b1; waddr = 6'd0; wdata = 32'h00c0_0513;
    tick();
    we = 1'b0;
    do_reset();
    chk("load_instr", d_instr[0], 32'h00c0_0513);
    tick();
    we = 1'b1; waddr = 6'd1; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    chk("we_in_run_ignored", d_instr[0], NOP);
    hlt = 1'b1;
    repeat (5) begin tick(); chk("hlt_freeze_pc", d_pc[0], 32'd1); end
    hlt = 1'b0;

    // Stall for three edges at pc=2.
    do_reset();
    repeat (3) tick();
    chk("pre_stall_pc", d_pc[0], 32'd2);
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_pc", d_pc[0], 32'd2);
      chk("stall_bubble", 32'(d_bub[0]), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("recover_pc", d_pc[0], 32'd2);
    chk("recover_bubble", 32'(d_bub[0]), 32'd1);
    tick();
    chk("resume_pc", d_pc[0], 32'd3);

    // Redirect wins over stall while stalled; pc=10 is misaligned for the byte instance.
    do_reset();
    tick();
    stall = 1'b1;
    tick();
    redir_v = 1'b1; redir_pc = 32'd10;
    tick();
    redir_v = 1'b0; stall = 1'b0;
    chk("redir_pc", d_pc[0], 32'd10);
    chk("redir_next_pc", d_npc[0], 32'd11);
    chk("redir_bubble", 32'(d_bub[0]), 32'd0);
    chk("redir_valid", 32'(d_iv[0]), 32'd1);
    chk("byte_misalign_fault", 32'(d_flt[1]), 32'd1);
    chk("byte_fault_nop", d_instr[1], NOP);
    do_reset();
    chk("rst_clears_fault", 32'(d_flt[1]), 32'd0);

    tick();
    redir_v = 1'b1; redir_pc = 32'h6;
    tick();
    redir_v = 1'b0;
    chk("byte_fault_6", 32'(d_flt[1]), 32'd1);
    chk("byte_fault_6_pc", d_pc[1], 32'h6);
    chk("byte_fault_6_nop", d_instr[1], NOP);
    do_reset();
    tick();
    redir_v = 1'b1; redir_pc = 32'h100;
    tick();
    redir_v = 1'b0;
    chk("byte_fault_range", 32'(d_flt[1]), 32'd1);
    chk("word_fault_range", 32'(d_flt[0]), 32'd1);
    do_reset();
    chk("rst_clears_fault_word", 32'(d_flt[0]), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst     = ($urandom_range(0, 39) == 0);
      hlt     = ($urandom_range(0, 7) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      redir_v = ($urandom_range(0, 7) == 0);
      redir_pc = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 300))
                                             : 32'(4 * $urandom_range(0, 17));
      we    = ($urandom_range(0, 3) == 0);
      waddr = 6'($urandom_range(0, 63));
      wdata = rand_word($urandom_range(0, 15) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
